// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling 8N1/8E1/8O1 UART receiver with a valid/ready holding register
module uart_rx_os #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int oversample = 16,
  parameter bit parity_en  = 1'b0,
  parameter bit parity_odd = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV = clk_freq / (baud_rate * oversample);
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(oversample);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q, rx_prev_q;
  logic [TW-1:0]   tc_q, tc_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            perr_q, perr_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            overrun_q, overrun_d;
  logic            tick, mid, fall, done, load;

  assign tick = tc_q == TW'(DIV - 1);
  assign mid  = tick && sc_q == SW'(oversample / 2 - 1);
  assign fall = rx_prev_q && !rxs_q;

  // Bit-level receive FSM; the tick and sample counters realign to each start edge
  always_comb begin
    state_d = state_q;
    tc_d    = tick ? '0 : tc_q + 1'b1;
    sc_d    = tick ? (sc_q == SW'(oversample - 1) ? '0 : sc_q + 1'b1) : sc_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    done    = 1'b0;
    case (state_q)
      IDLE:
        if (fall) begin
          state_d = START;
          tc_d    = '0;
          sc_d    = '0;
        end
      START:
        if (mid) begin
          state_d = rxs_q ? IDLE : DATA;
          bit_d   = '0;
        end
      DATA:
        if (mid) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = parity_en ? PARITY : STOP;
        end
      PARITY:
        if (mid) begin
          perr_d  = ^sh_q ^ rxs_q ^ parity_odd;
          state_d = STOP;
        end
      STOP:
        if (mid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load a finished frame if free or being drained, else flag overrun
  always_comb begin
    load         = done && (!rx_valid_q || rx_ready);
    rx_valid_d   = load ? 1'b1 : (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
    rx_data_d    = load ? sh_q : rx_data_q;
    frame_err_d  = load ? !rxs_q : frame_err_q;
    parity_err_d = load ? (parity_en && perr_q) : parity_err_q;
    overrun_d    = done && rx_valid_q && !rx_ready;
  end

  // Synchroniser, edge history and all state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      tc_q         <= '0;
      sc_q         <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      rx_prev_q    <= rxs_q;
      state_q      <= state_d;
      tc_q         <= tc_d;
      sc_q         <= sc_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = state_q != IDLE;
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver that terminates the serial line driven by the existing transmitter.
- Receives 8N1 frames (parity optional) on an asynchronous rx line. Samples each bit at mid-bit with a 16x baud tick.
- Presents each byte on a valid/ready holding register with framing, parity and overrun status.
- Runs directly on the system clock, with no derived uart clock.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line rate in bits per second.
- oversample, 16, baud ticks per bit. Must be even and at least 4.
- parity_en, 0, 1 = a parity bit follows the data bits.
- parity_odd, 0, 1 = odd parity, 0 = even parity. Ignored when parity_en = 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rx_ready  in  1  consumer accepts rx_data in any cycle where rx_valid = 1 and rx_ready = 1.
- rx_data  out  8  received byte. Valid while rx_valid = 1.
- rx_valid  out  1  holding register full.
- frame_err  out  1  stop bit sampled low for the byte in rx_data. Qualified by rx_valid.
- parity_err  out  1  parity mismatch for the byte in rx_data. Qualified by rx_valid. Held 0 when parity_en = 0.
- overrun  out  1  single-cycle pulse when a frame completes while rx_valid = 1.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE, all counters 0, synchroniser flops = 1.
  - rx_data = 0x00; rx_valid, frame_err, parity_err, overrun = 0.
  - A mid-frame reset abandons the frame with no output. After release, the receiver waits for a new falling edge.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs. Synchroniser latency is 2 clk.
- Tick generator:
  - div = clk_freq / (baud_rate * oversample), integer division; defaults give 6.
  - Free-running counter 0..div-1. tick = 1 for one clk when the counter equals div-1.
- Per-bit tick counter sc runs 0..oversample-1. A sample is taken on the tick where sc = oversample/2 - 1.
- States:
  - IDLE: a falling edge of rxs (previous 1, current 0) goes to START with sc = 0, and resets the tick counter so ticks are phase-aligned to the edge.
  - START: at the sample point, rxs = 1 is a false start and returns to IDLE (no output). rxs = 0 moves to DATA with sc restarting, bit index = 0.
  - DATA: one sample every oversample ticks, LSB first, shifted into a shift register. After bit 7, go to PARITY if parity_en, else STOP.
  - PARITY: sample one bit. perr = XOR of the 8 data bits, XOR the sampled bit, XOR parity_odd. Then go to STOP.
  - STOP: sample one bit; ferr = !rxs. On the next clk, return to IDLE and either load the holding register or raise overrun (below).
- STOP to IDLE happens at the stop-bit mid-sample. The last half of the stop bit is spent in IDLE, so back-to-back frames are caught.
- A low stop bit (break or framing error) does not trigger a new start until rxs has been seen high and then falls again.
- Holding register:
  - Load: when rx_valid = 0, or when rx_valid & rx_ready in the same cycle, set rx_data, frame_err, parity_err and rx_valid = 1.
  - Overrun: when rx_valid = 1 and rx_ready = 0, the new frame is discarded, overrun pulses for 1 clk, and old data and flags are kept.
  - Clear: rx_valid & rx_ready with no load in that cycle sets rx_valid to 0. rx_data keeps its value.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit.

Test Plan:
- Defaults (div 6, 96 clk/bit), send 0xA5 8N1, rx_ready held 1 -> rx_valid pulses 1 clk, rx_data = 0xA5, frame_err = 0; rising edge about 9.5 bit times after the start edge.
- Two back-to-back frames 0x00 then 0xFF, rx_ready = 0 throughout -> rx_data = 0x00, overrun pulses once at the end of frame 2; after rx_ready, rx_valid = 0 and the 0xFF frame is lost.
- rx low glitch of 20 clk while IDLE -> state returns to IDLE, rx_valid stays 0, busy high for about 48 clk only.
- Frame 0x3C with the stop bit held low, followed by 2 bit times high -> rx_data = 0x3C, frame_err = 1, no spurious second frame.
- parity_en = 1, parity_odd = 0, send 0x07 with parity bit 1 -> parity_err = 0; same byte with parity bit 0 -> parity_err = 1.
- Assert rst_n low at data bit 4 of frame 0x55, release, then send 0x81 -> only 0x81 is delivered, with no error flags.
